// File: rtl/step_mode_detector.sv
// step_mode_detector: recovers step mode (delta 0/1/4/8) and run start from a
// stream of counter samples; declares lock after LOCK_CNT matching deltas.
`default_nettype none

module step_mode_detector #(
  parameter int WIDTH    = 12,
  parameter int LOCK_CNT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_val,
  output logic [1:0]       mode,
  output logic [WIDTH-1:0] base_val,
  output logic             locked,
  output logic             err,
  output logic [3:0]       match_cnt
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARMED  = 3'd1,
    TRACK  = 3'd2,
    LOCKED = 3'd3,
    ERR    = 3'd4
  } state_t;

  localparam logic [3:0] LOCK_N = 4'(LOCK_CNT);

  state_t           state, state_nx;
  logic [WIDTH-1:0] prev, prev_nx, base_nx;
  logic [1:0]       cand_mode, cand_nx, mode_nx;
  logic [3:0]       mc_nx;
  logic             locked_nx, err_nx;

  logic [WIDTH-1:0] delta;
  logic [WIDTH-1:0] cand_step;
  logic             delta_legal;
  logic [1:0]       delta_mode;
  logic             delta_match;

  // Modulo-2^WIDTH subtraction makes wrap-around steps look like normal ones.
  assign delta = in_val - prev;

  always_comb begin
    delta_legal = 1'b1;
    delta_mode  = 2'd0;
    case (delta)
      WIDTH'(0): delta_mode = 2'd0;
      WIDTH'(1): delta_mode = 2'd1;
      WIDTH'(4): delta_mode = 2'd2;
      WIDTH'(8): delta_mode = 2'd3;
      default:   delta_legal = 1'b0;
    endcase
  end

  always_comb begin
    case (cand_mode)
      2'd0:    cand_step = WIDTH'(0);
      2'd1:    cand_step = WIDTH'(1);
      2'd2:    cand_step = WIDTH'(4);
      default: cand_step = WIDTH'(8);
    endcase
  end

  assign delta_match = (delta == cand_step);

  always_comb begin
    state_nx  = state;
    prev_nx   = prev;
    base_nx   = base_val;
    cand_nx   = cand_mode;
    mode_nx   = mode;
    mc_nx     = match_cnt;
    locked_nx = locked;
    err_nx    = err;

    if (clr) begin
      state_nx  = IDLE;
      prev_nx   = '0;
      base_nx   = '0;
      cand_nx   = 2'd0;
      mode_nx   = 2'd0;
      mc_nx     = 4'd0;
      locked_nx = 1'b0;
      err_nx    = 1'b0;
    end else if (in_valid && state != ERR) begin
      prev_nx = in_val;
      case (state)
        IDLE: begin
          base_nx  = in_val;
          state_nx = ARMED;
        end
        ARMED: begin
          if (delta_legal) begin
            cand_nx = delta_mode;
            mc_nx   = 4'd1;
            if (LOCK_N == 4'd1) begin
              state_nx  = LOCKED;
              locked_nx = 1'b1;
              mode_nx   = delta_mode;
            end else begin
              state_nx = TRACK;
            end
          end else begin
            state_nx = ERR;
          end
        end
        TRACK: begin
          if (delta_legal && delta_match) begin
            mc_nx = match_cnt + 4'd1;
            if (match_cnt + 4'd1 == LOCK_N) begin
              state_nx  = LOCKED;
              locked_nx = 1'b1;
              mode_nx   = cand_mode;
            end
          end else if (delta_legal) begin
            // New run starts at the sample preceding the differing delta.
            cand_nx = delta_mode;
            mc_nx   = 4'd1;
            base_nx = prev;
          end else begin
            state_nx = ERR;
          end
        end
        LOCKED: begin
          if (!delta_match) state_nx = ERR;
        end
        default: state_nx = state;
      endcase

      if (state_nx == ERR) begin
        err_nx    = 1'b1;
        locked_nx = 1'b0;
        mode_nx   = 2'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      prev      <= '0;
      cand_mode <= 2'd0;
      base_val  <= '0;
      mode      <= 2'd0;
      match_cnt <= 4'd0;
      locked    <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nx;
      prev      <= prev_nx;
      cand_mode <= cand_nx;
      base_val  <= base_nx;
      mode      <= mode_nx;
      match_cnt <= mc_nx;
      locked    <= locked_nx;
      err       <= err_nx;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_step_mode_detector.sv
// Scoreboard bench for step_mode_detector: directed plan scenarios plus
// randomized streams checked against a run-based reference model.
`default_nettype none

module tb_step_mode_detector;

  localparam int WIDTH    = 12;
  localparam int LOCK_CNT = 4;

  typedef struct packed {
    logic [1:0]       mode;
    logic [WIDTH-1:0] base;
    logic             locked;
    logic             err;
    logic [3:0]       mc;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clr = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_val = '0;
  logic [1:0]       mode;
  logic [WIDTH-1:0] base_val;
  logic             locked;
  logic             err;
  logic [3:0]       match_cnt;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];

  step_mode_detector #(.WIDTH(WIDTH), .LOCK_CNT(LOCK_CNT)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_val(in_val),
    .mode(mode), .base_val(base_val), .locked(locked), .err(err),
    .match_cnt(match_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: samples seen since clear, the current run (step, length,
  // first sample) and a sticky error bit.
  int               m_nsamp;
  logic [WIDTH-1:0] m_prev, m_base;
  int               m_step, m_len;
  bit               m_err;

  function automatic logic [1:0] step_to_mode(input int s);
    case (s)
      1:       return 2'd1;
      4:       return 2'd2;
      8:       return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.err    = m_err;
    e.locked = !m_err && (m_len >= LOCK_CNT);
    e.mode   = e.locked ? step_to_mode(m_step) : 2'd0;
    e.base   = m_base;
    e.mc     = 4'((m_len > LOCK_CNT) ? LOCK_CNT : m_len);
    return e;
  endfunction

  task automatic model_clear();
    m_nsamp = 0; m_prev = '0; m_base = '0; m_step = 0; m_len = 0; m_err = 0;
  endtask

  task automatic model_sample(input logic [WIDTH-1:0] v);
    int d;
    bit legal;
    if (m_err) return;
    if (m_nsamp == 0) begin
      m_base  = v;
      m_prev  = v;
      m_nsamp = 1;
      return;
    end
    d = int'(WIDTH'(v - m_prev));
    legal = (d == 0) || (d == 1) || (d == 4) || (d == 8);
    if (!legal) m_err = 1;
    else if (m_len >= LOCK_CNT) begin
      if (d != m_step) m_err = 1;
    end else if (m_len == 0) begin
      m_step = d; m_len = 1;
    end else if (d == m_step) m_len++;
    else begin
      m_base = m_prev; m_step = d; m_len = 1;
    end
    m_prev = v;
    m_nsamp++;
  endtask

  // One clock of stimulus, entered and left at a falling edge.
  task automatic cycle(input logic c, input logic v, input logic [WIDTH-1:0] x);
    clr = c; in_valid = v; in_val = x;
    if (c) begin
      model_clear();
      exp_q.push_back(model_out());
    end else if (v) begin
      model_sample(x);
      exp_q.push_back(model_out());
    end
    @(negedge clk);
    clr = 1'b0; in_valid = 1'b0;
  endtask

  task automatic sample(input logic [WIDTH-1:0] x, input int gap);
    cycle(1'b0, 1'b1, x);
    for (int i = 0; i < gap; i++) cycle(1'b0, 1'b0, '0);
  endtask

  task automatic expect_now(input string name, input exp_t want);
    exp_t got;
    got = '{mode: mode, base: base_val, locked: locked, err: err, mc: match_cnt};
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got mode=%0d base=%h locked=%b err=%b mc=%0d, want mode=%0d base=%h locked=%b err=%b mc=%0d",
               name, got.mode, got.base, got.locked, got.err, got.mc,
               want.mode, want.base, want.locked, want.err, want.mc);
    end
  endtask

  // Monitor: each accepted sample or clear produces one registered update.
  always @(posedge clk) begin
    if (rst_n && (clr || in_valid)) begin
      #1;
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL scoreboard: output update with no expectation queued");
      end else begin
        expect_now("scoreboard", exp_q.pop_front());
      end
    end
  end

  function automatic exp_t mk(input logic [1:0] md, input logic [WIDTH-1:0] b,
                              input logic l, input logic e, input logic [3:0] c);
    exp_t r;
    r.mode = md; r.base = b; r.locked = l; r.err = e; r.mc = c;
    return r;
  endfunction

  initial begin
    int cur_step;
    int r;
    logic [WIDTH-1:0] v;
    int steps[4];
    steps[0] = 0; steps[1] = 1; steps[2] = 4; steps[3] = 8;
    model_clear();

    #2;
    expect_now("reset_state", mk(2'd0, '0, 1'b0, 1'b0, 4'd0));
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Plan 1: increment-by-1 lock.
    for (int i = 0; i < 5; i++) sample(WIDTH'(12'h100 + i), 0);
    expect_now("t1_lock", mk(2'd1, 12'h100, 1'b1, 1'b0, 4'd4));

    // Plan 2: step 8 across the wrap with gaps.
    cycle(1'b1, 1'b0, '0);
    sample(12'hFF0, 2); sample(12'hFF8, 2); sample(12'h000, 2);
    sample(12'h008, 2); sample(12'h010, 2);
    expect_now("t2_wrap_lock", mk(2'd3, 12'hFF0, 1'b1, 1'b0, 4'd4));

    // Plan 3: illegal delta, sticky error, clear, clear-over-sample.
    cycle(1'b1, 1'b0, '0);
    sample(12'h010, 0); sample(12'h013, 0);
    expect_now("t3_err", mk(2'd0, 12'h010, 1'b0, 1'b1, 4'd0));
    sample(12'h014, 0); sample(12'h015, 0);
    expect_now("t3_sticky", mk(2'd0, 12'h010, 1'b0, 1'b1, 4'd0));
    cycle(1'b1, 1'b0, '0);
    expect_now("t3_clr", mk(2'd0, '0, 1'b0, 1'b0, 4'd0));
    cycle(1'b1, 1'b1, 12'h123);
    expect_now("t3_clr_drop", mk(2'd0, '0, 1'b0, 1'b0, 4'd0));
    sample(12'h200, 0);
    expect_now("t3_rearm", mk(2'd0, 12'h200, 1'b0, 1'b0, 4'd0));

    // Plan 4: run restart.
    cycle(1'b1, 1'b0, '0);
    foreach (steps[i]) begin end
    sample(12'h000, 0); sample(12'h004, 0); sample(12'h008, 0);
    sample(12'h009, 0);
    expect_now("t4_restart", mk(2'd0, 12'h008, 1'b0, 1'b0, 4'd1));
    sample(12'h00A, 0); sample(12'h00B, 0); sample(12'h00C, 0);
    expect_now("t4_lock", mk(2'd1, 12'h008, 1'b1, 1'b0, 4'd4));

    // Plan 5: constant-stream lock then break.
    cycle(1'b1, 1'b0, '0);
    for (int i = 0; i < 5; i++) sample(12'h055, 0);
    expect_now("t5_lock", mk(2'd0, 12'h055, 1'b1, 1'b0, 4'd4));
    sample(12'h056, 0);
    expect_now("t5_break", mk(2'd0, 12'h055, 1'b0, 1'b1, 4'd4));

    // Plan 6: asynchronous reset mid-run.
    cycle(1'b1, 1'b0, '0);
    sample(12'h300, 0); sample(12'h301, 0); sample(12'h302, 0);
    expect_now("t6_pre", mk(2'd0, 12'h300, 1'b0, 1'b0, 4'd2));
    #2 rst_n = 1'b0;
    #1 expect_now("t6_async_rst", mk(2'd0, '0, 1'b0, 1'b0, 4'd0));
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    sample(12'h303, 0);
    expect_now("t6_reenter", mk(2'd0, 12'h303, 1'b0, 1'b0, 4'd0));

    // Randomized streams, biased towards long runs so locks occur.
    cur_step = 1;
    v = WIDTH'($urandom);
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 99);
      if (r < 3 || (m_err && r < 30)) begin
        cycle(1'b1, $urandom_range(0, 1) == 1, WIDTH'($urandom));
        cur_step = steps[$urandom_range(0, 3)];
      end else begin
        r = $urandom_range(0, 99);
        if (r < 8) cur_step = steps[$urandom_range(0, 3)];
        if (r >= 8 && r < 12) v = v + WIDTH'($urandom_range(2, 3) + 4 * $urandom_range(0, 1));
        else v = v + WIDTH'(cur_step);
        sample(v, $urandom_range(0, 2));
      end
    end

    @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
